axi_lite_arbiter: RTL
=====================

// Module: axi_lite_arbiter
// PURPOSE
//  2:1 AXI-lite arbiter placed directly upstream of the SRAM slave.
//  Master 0 = IFU (read-only), master 1 = LSU (read + write).
//  One transaction outstanding at a time; the grant is held until the response handshake.
//  Write requests present AW and W together, as the SRAM slave requires.
// PARAMETERS
//  ADDR_W  32  address width, all channels
//  DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//  clk                                    in   1       clock; all logic on posedge
//  rst_n                                  in   1       asynchronous, active-low reset
//  m0_arvalid, m0_rready                  in   1       IFU read request / response ready
//  m0_araddr                              in   ADDR_W  IFU read address
//  m0_arready, m0_rvalid                  out  1       IFU handshakes
//  m0_rdata / m0_rresp                    out  DATA_W/2  IFU read data / response
//  m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready  in  1  LSU handshakes
//  m1_araddr, m1_awaddr                   in   ADDR_W  LSU addresses
//  m1_wdata / m1_wstrb                    in   DATA_W/(DATA_W/8)  LSU write data / strobe
//  m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid  out  1  LSU handshakes
//  m1_rdata / m1_rresp / m1_bresp         out  DATA_W/2/2  LSU responses
//  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready  out  1  to slave
//  s_araddr, s_awaddr / s_wdata / s_wstrb out  ADDR_W/DATA_W/DATA_W/8  to slave
//  s_arready, s_rvalid, s_awready, s_wready, s_bvalid  in  1  from slave
//  s_rdata / s_rresp / s_bresp            in   DATA_W/2/2  from slave
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; aw_done=w_done=0; RR pointer=M0; every output 0.
//  - States:
//    - IDLE: all slave valids and readies 0; all master readies and valids 0.
//    - RD0, RD1: read granted to M0 or M1.
//    - WR1: write granted to M1.
//  - IDLE arbitration is registered: request seen at cycle N, slave valid asserts at N+1.
//    - Requests: W1 = m1_awvalid & m1_wvalid; R1 = m1_arvalid; R0 = m0_arvalid.
//    - Fixed priority: W1 > R1 > R0.
//  - RDx: slave AR channel is driven from master x; arready passes through combinationally.
//    - ar_done is set at the AR handshake; s_arvalid is masked to 0 once ar_done is set.
//    - R channel: rvalid/rdata/rresp pass through to master x; s_rready = mx_rready.
//    - s_rvalid & s_rready -> IDLE; ar_done is cleared.
//  - WR1: aw/w routed from M1; aw_done and w_done are tracked independently.
//    - Each valid is masked once its handshake completes; bresp passes through.
//    - s_bvalid & s_bready -> IDLE; both done flags are cleared.
//  - Non-granted master: all of its readies and valids are 0; its requests stay pending.
//  - Back-to-back: response completes in cycle N -> IDLE at N+1 -> next grant at N+2.
//    There is exactly one bubble cycle.
//  - Responses are never generated or altered locally.
//    Slave r/b valids arriving in IDLE are ignored (s_rready = s_bready = 0).
//  - A master dropping valid before its handshake is a protocol violation.
//    The arbiter keeps the grant and waits.
//  - Reset asserted mid-transaction: immediate return to IDLE; no response reaches the master.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN:
//  - Defined: priority between M0 and M1 alternates.
//    - RR pointer names the favoured master; it flips to the other master when a granted
//      transaction completes.
//    - Inside M1, W1 > R1 still holds.
//  - Undefined: fixed W1 > R1 > R0. M0 can starve under continuous LSU traffic.
// TESTING
//  1. Reset: rst_n=0 mid-RD0 -> all outputs 0 within the same cycle; IDLE after release.
//  2. M0 read only: m0_araddr=0x8000_0000 -> s_arvalid at +1 cycle, araddr passed through;
//     m0_rdata equals s_rdata; IDLE after rvalid&rready.
//  3. Simultaneous R0 + W1 (awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=0xF), fixed mode:
//     -> W1 is granted first; m0_arready=0 until the bvalid handshake; R0 is granted 2 cycles later.
//  4. Write with s_awready one cycle before s_wready -> s_awvalid drops after the AW handshake;
//     s_wvalid holds until wready; exactly one bvalid reaches M1.
//  5. Round-robin enabled, R0 and R1 continuously asserted for 8 transactions
//     -> grants alternate M0, M1, M0, ...; fixed mode -> all 8 go to M1.
//  6. s_bresp=2'b10 -> m1_bresp=2'b10 unchanged; a stray s_rvalid in IDLE is dropped.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: 2:1 AXI-lite arbiter in front of the SRAM slave.
// M0 = IFU (read only), M1 = LSU (read + write). One transaction in flight;
// the grant is held until the response handshake, then one idle bubble.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating M0/M1 priority).
module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0 (IFU)
  input  logic                  m0_arvalid,
  input  logic [ADDR_W-1:0]     m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  // master 1 (LSU)
  input  logic                  m1_arvalid,
  input  logic [ADDR_W-1:0]     m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_awvalid,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [1:0]            m1_bresp,
  // slave side
  output logic                  s_arvalid,
  output logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_awvalid,
  output logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t state, state_nxt;
  logic   ar_done, aw_done, w_done;
  logic   w1_req, r1_req, r0_req;
  logic   xfer_end;

  assign w1_req   = m1_awvalid & m1_wvalid;
  assign r1_req   = m1_arvalid;
  assign r0_req   = m0_arvalid;
  assign xfer_end = (state != IDLE) && (state_nxt == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_m1;  // 1: M1 favoured, 0: M0 favoured

  // Favour the other master once a granted transaction completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rr_m1 <= 1'b0;
    else if (xfer_end) rr_m1 <= (state == RD0);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration in IDLE and completion detection in the granted states
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (!rr_m1 && r0_req) state_nxt = RD0;
        else if (w1_req)      state_nxt = WR1;
        else if (r1_req)      state_nxt = RD1;
        else if (r0_req)      state_nxt = RD0;
`else
        if (w1_req)      state_nxt = WR1;
        else if (r1_req) state_nxt = RD1;
        else if (r0_req) state_nxt = RD0;
`endif
      end
      RD0:     if (s_rvalid && m0_rready) state_nxt = IDLE;
      RD1:     if (s_rvalid && m1_rready) state_nxt = IDLE;
      WR1:     if (s_bvalid && m1_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel handshake flags; cleared when the transaction completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (xfer_end) begin
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) ar_done <= 1'b1;
      if (s_awvalid && s_awready) aw_done <= 1'b1;
      if (s_wvalid  && s_wready)  w_done  <= 1'b1;
    end
  end

  // Channel routing for the granted master; everything else held at zero
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    case (state)
      RD0: begin
        s_arvalid  = m0_arvalid & ~ar_done;
        s_araddr   = m0_araddr;
        m0_arready = s_arready & ~ar_done;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        s_rready   = m0_rready;
      end
      RD1: begin
        s_arvalid  = m1_arvalid & ~ar_done;
        s_araddr   = m1_araddr;
        m1_arready = s_arready & ~ar_done;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        s_rready   = m1_rready;
      end
      WR1: begin
        s_awvalid  = m1_awvalid & ~aw_done;
        s_awaddr   = m1_awaddr;
        m1_awready = s_awready & ~aw_done;
        s_wvalid   = m1_wvalid & ~w_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m1_wready  = s_wready & ~w_done;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule
